// File: rtl/led_count_pkg.sv
// Shared definitions for the LED-rate counter: mode encodings.
package led_count_pkg;

   localparam int unsigned MODE_W = 2;

   typedef logic [MODE_W-1:0] mode_t;

   localparam mode_t MODE_UP     = 2'b00;
   localparam mode_t MODE_DOWN   = 2'b01;
   localparam mode_t MODE_BOUNCE = 2'b10;
   localparam mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/led_count_prescaler.sv
// Free-running prescaler: one step strobe per 2^PRE_BITS enabled clocks.
module led_count_prescaler #(
   parameter int unsigned PRE_BITS = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic step
);

   logic [PRE_BITS-1:0] pre_q;
   logic [PRE_BITS-1:0] pre_d;

   // clr restarts the period even while disabled so a load always gets a full period.
   always_comb begin
      pre_d = pre_q;
      if (clr) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign step = en && (pre_q == '1);

endmodule

// File: rtl/led_count_gen.sv
// LED-rate counter with up/down/bounce/hold modes and synchronous load.
// Optional wrap_pulse output enabled by defining LED_COUNT_WRAP_PULSE_EN.
module led_count_gen
   import led_count_pkg::*;
#(
   parameter int unsigned     WIDTH     = 4,
   parameter int unsigned     PRE_BITS  = 25,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(4'hF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  count_out,
   output logic              dir_up
`ifdef LED_COUNT_WRAP_PULSE_EN
   ,
   output logic              wrap_pulse
`endif
);

   localparam logic [WIDTH-1:0] CntMax = '1;

   logic             step;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             dir_q;
   logic             dir_d;
   logic             at_max;
   logic             at_min;

   led_count_prescaler #(
      .PRE_BITS (PRE_BITS)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (load),
      .step  (step)
   );

   assign at_max = (count_q == CntMax);
   assign at_min = (count_q == '0);

   // Load wins over step; a step in hold mode leaves the count alone.
   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      if (load) begin
         count_d = load_val;
      end else if (step) begin
         case (mode)
            MODE_UP:   count_d = count_q + 1'b1;
            MODE_DOWN: count_d = count_q - 1'b1;
            MODE_BOUNCE: begin
               if (dir_q) begin
                  if (at_max) begin
                     count_d = CntMax - 1'b1;
                     dir_d   = 1'b0;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end else begin
                  if (at_min) begin
                     count_d = WIDTH'(1);
                     dir_d   = 1'b1;
                  end else begin
                     count_d = count_q - 1'b1;
                  end
               end
            end
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= RESET_VAL;
         dir_q   <= 1'b1;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
      end
   end

   assign count_out = count_q;
   assign dir_up    = dir_q;

`ifdef LED_COUNT_WRAP_PULSE_EN
   logic wrap_d;
   logic wrap_q;

   // A wrap or bounce reversal only happens on a step that a load did not override.
   always_comb begin
      wrap_d = 1'b0;
      if (step && !load) begin
         case (mode)
            MODE_UP:     wrap_d = at_max;
            MODE_DOWN:   wrap_d = at_min;
            MODE_BOUNCE: wrap_d = dir_q ? at_max : at_min;
            default:     wrap_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap_pulse = wrap_q;
`endif

endmodule

// File: tb/tb_led_count_gen.sv
// Directed bench for led_count_gen with WIDTH=4, PRE_BITS=2 (a step every 4 enabled clocks).
module tb_led_count_gen;
   import led_count_pkg::*;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic       en       = 1'b0;
   logic [1:0] mode     = 2'b00;
   logic       load     = 1'b0;
   logic [3:0] load_val = 4'h0;
   logic [3:0] count_out;
   logic       dir_up;
`ifdef LED_COUNT_WRAP_PULSE_EN
   logic       wrap_pulse;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   led_count_gen #(
      .WIDTH     (4),
      .PRE_BITS  (2),
      .RESET_VAL (4'hF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .load       (load),
      .load_val   (load_val),
      .count_out  (count_out),
      .dir_up     (dir_up)
`ifdef LED_COUNT_WRAP_PULSE_EN
      ,
      .wrap_pulse (wrap_pulse)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      vectors++;
      if (count_out !== 4'hF) begin
         miscompares++;
         $display("FAIL reset_count: got %h want f", count_out);
      end
      vectors++;
      if (dir_up !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_dir: got %b want 1", dir_up);
      end
`ifdef LED_COUNT_WRAP_PULSE_EN
      vectors++;
      if (wrap_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_wrap: got %b want 0", wrap_pulse);
      end
`endif
      tick();
      tick();
   endtask

   // Release reset with down mode; steps at edges 4, 8, ... and 0 -> F at edge 64.
   task automatic test_down();
      logic [3:0] exp;
      mode  = MODE_DOWN;
      en    = 1'b1;
      rst_n = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         tick();
         exp = 4'hF - 4'(k / 4);
         vectors++;
         if (count_out !== exp) begin
            miscompares++;
            $display("FAIL down_count edge %0d: got %h want %h", k, count_out, exp);
         end
`ifdef LED_COUNT_WRAP_PULSE_EN
         vectors++;
         if (wrap_pulse !== (k == 64)) begin
            miscompares++;
            $display("FAIL down_wrap edge %0d: got %b want %b", k, wrap_pulse, (k == 64));
         end
`endif
      end
   endtask

   task automatic test_up();
      logic [3:0] exp_tab [4];
      exp_tab = '{4'hE, 4'hF, 4'h0, 4'h1};
      mode     = MODE_UP;
      load     = 1'b1;
      load_val = 4'hE;
      for (int j = 0; j <= 12; j++) begin
         tick();
         load = 1'b0;
         vectors++;
         if (count_out !== exp_tab[j / 4]) begin
            miscompares++;
            $display("FAIL up_count j=%0d: got %h want %h", j, count_out, exp_tab[j / 4]);
         end
`ifdef LED_COUNT_WRAP_PULSE_EN
         vectors++;
         if (wrap_pulse !== (j == 8)) begin
            miscompares++;
            $display("FAIL up_wrap j=%0d: got %b want %b", j, wrap_pulse, (j == 8));
         end
`endif
      end
   endtask

   task automatic test_bounce();
      logic [3:0] hi_tab [5];
      logic [3:0] lo_tab [4];
      hi_tab = '{4'hD, 4'hE, 4'hF, 4'hE, 4'hD};
      lo_tab = '{4'h1, 4'h0, 4'h1, 4'h2};
      mode     = MODE_BOUNCE;
      load     = 1'b1;
      load_val = 4'hD;
      for (int j = 0; j <= 16; j++) begin
         tick();
         load = 1'b0;
         vectors++;
         if (count_out !== hi_tab[j / 4]) begin
            miscompares++;
            $display("FAIL bounce_hi_count j=%0d: got %h want %h", j, count_out, hi_tab[j / 4]);
         end
         vectors++;
         if (dir_up !== (j < 12)) begin
            miscompares++;
            $display("FAIL bounce_hi_dir j=%0d: got %b want %b", j, dir_up, (j < 12));
         end
`ifdef LED_COUNT_WRAP_PULSE_EN
         vectors++;
         if (wrap_pulse !== (j == 12)) begin
            miscompares++;
            $display("FAIL bounce_hi_wrap j=%0d: got %b want %b", j, wrap_pulse, (j == 12));
         end
`endif
      end
      load     = 1'b1;
      load_val = 4'h1;
      for (int j = 0; j <= 12; j++) begin
         tick();
         load = 1'b0;
         vectors++;
         if (count_out !== lo_tab[j / 4]) begin
            miscompares++;
            $display("FAIL bounce_lo_count j=%0d: got %h want %h", j, count_out, lo_tab[j / 4]);
         end
         vectors++;
         if (dir_up !== (j >= 8)) begin
            miscompares++;
            $display("FAIL bounce_lo_dir j=%0d: got %b want %b", j, dir_up, (j >= 8));
         end
      end
   endtask

   task automatic test_enable_hold();
      mode     = MODE_UP;
      load     = 1'b1;
      load_val = 4'h7;
      tick();
      load = 1'b0;
      tick();
      tick();
      en = 1'b0;
      for (int j = 0; j < 10; j++) begin
         tick();
         vectors++;
         if (count_out !== 4'h7) begin
            miscompares++;
            $display("FAIL enable_frozen j=%0d: got %h want 7", j, count_out);
         end
      end
      en = 1'b1;
      tick();
      vectors++;
      if (count_out !== 4'h7) begin
         miscompares++;
         $display("FAIL enable_resume_early: got %h want 7", count_out);
      end
      tick();
      vectors++;
      if (count_out !== 4'h8) begin
         miscompares++;
         $display("FAIL enable_resume_step: got %h want 8", count_out);
      end
      mode = MODE_HOLD;
      for (int j = 0; j < 10; j++) begin
         tick();
         vectors++;
         if (count_out !== 4'h8) begin
            miscompares++;
            $display("FAIL hold_count j=%0d: got %h want 8", j, count_out);
         end
      end
      // Prescaler kept running through hold, so the next step is only 2 edges away.
      mode = MODE_UP;
      tick();
      vectors++;
      if (count_out !== 4'h8) begin
         miscompares++;
         $display("FAIL hold_exit_early: got %h want 8", count_out);
      end
      tick();
      vectors++;
      if (count_out !== 4'h9) begin
         miscompares++;
         $display("FAIL hold_exit_step: got %h want 9", count_out);
      end
   endtask

   task automatic test_load_vs_step();
      logic [3:0] exp;
      for (int j = 0; j < 3; j++) begin
         tick();
      end
      load     = 1'b1;
      load_val = 4'h5;
      tick();
      load = 1'b0;
      vectors++;
      if (count_out !== 4'h5) begin
         miscompares++;
         $display("FAIL load_priority: got %h want 5", count_out);
      end
      for (int j = 1; j <= 4; j++) begin
         tick();
         exp = (j == 4) ? 4'h6 : 4'h5;
         vectors++;
         if (count_out !== exp) begin
            miscompares++;
            $display("FAIL load_restart j=%0d: got %h want %h", j, count_out, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] exp;
      mode     = MODE_BOUNCE;
      load     = 1'b1;
      load_val = 4'hF;
      tick();
      load = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick();
      end
      vectors++;
      if ({count_out, dir_up} !== {4'hE, 1'b0}) begin
         miscompares++;
         $display("FAIL pre_reset_state: got %h/%b want e/0", count_out, dir_up);
      end
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (count_out !== 4'hF) begin
         miscompares++;
         $display("FAIL async_reset_count: got %h want f", count_out);
      end
      vectors++;
      if (dir_up !== 1'b1) begin
         miscompares++;
         $display("FAIL async_reset_dir: got %b want 1", dir_up);
      end
`ifdef LED_COUNT_WRAP_PULSE_EN
      vectors++;
      if (wrap_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset_wrap: got %b want 0", wrap_pulse);
      end
`endif
      tick();
      tick();
      mode  = MODE_DOWN;
      rst_n = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         tick();
         exp = (j == 4) ? 4'hE : 4'hF;
         vectors++;
         if (count_out !== exp) begin
            miscompares++;
            $display("FAIL post_reset_step j=%0d: got %h want %h", j, count_out, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_down();
      test_up();
      test_bounce();
      test_enable_hold();
      test_load_vs_step();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
